// File: rtl/alu_shift_seq_if.sv
// Bundles the request, response and ALU-side signals of the shift/rotate
// micro-sequencer. The slave modport is the sequencer; the master modport is
// its environment (instruction decoder, response consumer and ALU).
interface alu_shift_seq_if;
  // request from the decoder
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic       req_cy;
  logic       flush;

  // ALU operand and control lines
  logic [7:0] alu_op;
  logic       alu_si;
  logic [1:0] alu_sh;
  logic [1:0] alu_oe;
  logic       alu_la;
  logic       alu_lb;
  logic       alu_r;
  logic       alu_s;
  logic       alu_v;
  logic       alu_ne;
  logic       alu_ci;
  logic       alu_l;
  logic       alu_h;

  // ALU results
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_shift_dbl;

  // response to the consumer
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  req_valid, req_op, req_data, req_cy, flush,
    input  alu_result, alu_zero, alu_shift_dbl,
    input  rsp_ready,
    output req_ready,
    output alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb,
    output alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h,
    output rsp_valid, rsp_data, rsp_flags, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_data, req_cy, flush,
    output alu_result, alu_zero, alu_shift_dbl,
    output rsp_ready,
    input  req_ready,
    input  alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb,
    input  alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err, busy
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Micro-sequencer for the CB-prefix shift/rotate group. Runs one request at a
// time through the shared ALU as SETUP -> SHIFT -> RESULT, captures the ALU
// result and carry-out, and returns them over a valid/ready response port.
// The shift itself is done entirely by the ALU; this block only sequences it.
module alu_shift_seq (
  input  logic           clk,
  input  logic           reset,
  alu_shift_seq_if.slave bus
);

  // shared ALU header encodings
  localparam logic [1:0] NO_SH  = 2'd0;
  localparam logic [1:0] L_SH   = 2'd1;
  localparam logic [1:0] R_SH   = 2'd2;
  localparam logic [1:0] NO_OE  = 2'd0;
  localparam logic [1:0] SH_OE  = 2'd1;
  localparam logic [1:0] RES_OE = 2'd2;
  localparam logic       NO_LD  = 1'b0;
  localparam logic       BUS_LD = 1'b1;

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, RESULT, DONE} state_t;

  typedef struct packed {
    logic [7:0] op;
    logic       si;
    logic [1:0] sh;
    logic [1:0] oe;
    logic       la;
    logic       lb;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{op: 8'h00, si: 1'b0, sh: NO_SH, oe: NO_OE,
                                la: NO_LD, lb: NO_LD, r: 1'b1, s: 1'b1,
                                v: 1'b1, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0};

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic       cy_q, cy_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic [7:0] res_q, res_d;
  logic       err_q, err_d;
  ctl_t       ctl_q, ctl_d;
  logic       si_sel;
  logic [1:0] dir_sel;

  // state, captured operands/results and registered ALU controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      data_q  <= 8'h00;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      res_q   <= 8'h00;
      err_q   <= 1'b0;
      ctl_q   <= CTL_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      z_q     <= z_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ctl_q   <= ctl_d;
    end
  end

  // next state: flush wins over everything, including a request in IDLE
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.req_valid) state_d = (bus.req_op == OP_SWAP) ? DONE : SETUP;
        SETUP:   state_d = SHIFT;
        SHIFT:   state_d = RESULT;
        RESULT:  state_d = DONE;
        DONE:    if (bus.rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // request latch and response capture; a flush discards the response
  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    cy_d   = cy_q;
    c_d    = c_q;
    z_d    = z_q;
    res_d  = res_q;
    err_d  = err_q;
    if (bus.flush) begin
      c_d   = 1'b0;
      z_d   = 1'b0;
      res_d = 8'h00;
      err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_d   = bus.req_op;
            data_d = bus.req_data;
            cy_d   = bus.req_cy;
            c_d    = 1'b0;
            z_d    = 1'b0;
            res_d  = 8'h00;
            err_d  = (bus.req_op == OP_SWAP);
          end
        end
        SHIFT:   c_d = bus.alu_shift_dbl;
        RESULT: begin
          res_d = bus.alu_result;
          z_d   = bus.alu_zero;
        end
        default: ;
      endcase
    end
  end

  // ALU control vector decoded from the upcoming state so it is a clean
  // register output for the whole cycle of that state
  always_comb begin
    si_sel  = 1'b0;
    dir_sel = R_SH;
    case (op_q)
      OP_RLC:  begin si_sel = data_q[7]; dir_sel = L_SH; end
      OP_RRC:  begin si_sel = data_q[0]; dir_sel = R_SH; end
      OP_RL:   begin si_sel = cy_q;      dir_sel = L_SH; end
      OP_RR:   begin si_sel = cy_q;      dir_sel = R_SH; end
      OP_SLA:  begin si_sel = 1'b0;      dir_sel = L_SH; end
      OP_SRA:  begin si_sel = data_q[7]; dir_sel = R_SH; end
      OP_SRL:  begin si_sel = 1'b0;      dir_sel = R_SH; end
      default: begin si_sel = 1'b0;      dir_sel = R_SH; end
    endcase

    ctl_d = CTL_IDLE;
    case (state_d)
      SHIFT: begin
        ctl_d.op = data_q;
        ctl_d.si = si_sel;
        ctl_d.sh = dir_sel;
        ctl_d.oe = SH_OE;
        ctl_d.la = BUS_LD;
        ctl_d.lb = BUS_LD;
        ctl_d.l  = 1'b1;
      end
      RESULT: begin
        ctl_d.oe = RES_OE;
        ctl_d.h  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_op    = ctl_q.op;
  assign bus.alu_si    = ctl_q.si;
  assign bus.alu_sh    = ctl_q.sh;
  assign bus.alu_oe    = ctl_q.oe;
  assign bus.alu_la    = ctl_q.la;
  assign bus.alu_lb    = ctl_q.lb;
  assign bus.alu_r     = ctl_q.r;
  assign bus.alu_s     = ctl_q.s;
  assign bus.alu_v     = ctl_q.v;
  assign bus.alu_ne    = ctl_q.ne;
  assign bus.alu_ci    = ctl_q.ci;
  assign bus.alu_l     = ctl_q.l;
  assign bus.alu_h     = ctl_q.h;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = res_q;
  assign bus.rsp_flags = {z_q, 1'b0, 1'b0, c_q};   // {Z,N,H,C}
  assign bus.rsp_err   = err_q;

endmodule
